saci_slave: RTL and testbench

- SACI responder (slave) for ASIC register banks.
- Deserializes frames that the chip-level SACI master drives on cmd_i while sel_n_i is low.
- Issues one parallel register request per frame to the core and serializes the response back on rsp_o.
- Sits at the chip pad boundary; all logic runs in the SACI clock domain (clk_i).

---
 rtl/saci_slave.sv | 196 +++++++++++++++++++
 tb/tb_saci_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/saci_slave.sv
// SACI responder: deserializes a command frame from cmd_i, issues one register
// request to the core, and serializes the response back on rsp_o.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start bit (sel_n_i low and cmd_i high)
// ST_RX   | shifting in R/W, cmd, addr and (writes) data
// ST_REQ  | req_o held to the core until ack_i
// ST_TX   | shifting response out on rsp_o
// ST_DONE | frame finished, waiting for sel_n_i to deassert
module saci_slave #(
    parameter int g_cmd_w  = 7,
    parameter int g_addr_w = 12,
    parameter int g_data_w = 32
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                sel_n_i,
    input  logic                cmd_i,
    output logic                rsp_o,
    output logic                req_o,
    output logic                wr_o,
    output logic [g_cmd_w-1:0]  cmd_o,
    output logic [g_addr_w-1:0] addr_o,
    output logic [g_data_w-1:0] wdata_o,
    input  logic [g_data_w-1:0] rdata_i,
    input  logic                ack_i,
    output logic                abort_o,
    output logic                busy_o
);

    localparam int HDR_W = g_cmd_w + g_addr_w;
    localparam int PAY_W = HDR_W + g_data_w;
    localparam int RSP_W = 2 + PAY_W;
    localparam int TXS_W = RSP_W - 1;
    localparam int CNT_W = $clog2(RSP_W + 1);

    // bit_cnt in ST_RX indexes the bits after the start bit (R/W is index 0)
    localparam logic [CNT_W-1:0] RX_LAST_RD = CNT_W'(HDR_W);
    localparam logic [CNT_W-1:0] RX_LAST_WR = CNT_W'(PAY_W);
    localparam logic [CNT_W-1:0] TX_LEN_RD  = CNT_W'(RSP_W);
    localparam logic [CNT_W-1:0] TX_LEN_WR  = CNT_W'(2 + HDR_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_REQ,
        ST_TX,
        ST_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic               rx_wr;
    logic [PAY_W-1:0]   rx_sr;
    logic [PAY_W-1:0]   rx_sr_nxt;
    logic [TXS_W-1:0]   tx_sr;
    logic [g_data_w-1:0] rsp_data;
    logic               rx_last;
    logic               tx_last;
    logic               abort_evt;
    logic               rx_done;
    logic               ack_evt;
    logic               tx_done;

    assign rx_sr_nxt = {rx_sr[PAY_W-2:0], cmd_i};
    assign rx_last   = (bit_cnt == (rx_wr ? RX_LAST_WR : RX_LAST_RD));
    assign tx_last   = (bit_cnt == (wr_o ? TX_LEN_WR : TX_LEN_RD));
    assign rsp_data  = wr_o ? {g_data_w{1'b0}} : rdata_i;
    assign busy_o    = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        abort_evt = 1'b0;
        rx_done   = 1'b0;
        ack_evt   = 1'b0;
        tx_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!sel_n_i && cmd_i) state_d = ST_RX;
            end
            ST_RX: begin
                if (sel_n_i) begin
                    abort_evt = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rx_last && bit_cnt != '0) begin
                    rx_done = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sel_n_i) begin
                    abort_evt = 1'b1;
                    state_d   = ST_IDLE;
                end else if (ack_i) begin
                    ack_evt = 1'b1;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (sel_n_i) begin
                    abort_evt = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tx_last) begin
                    tx_done = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (sel_n_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bit_cnt <= '0;
            rx_wr   <= 1'b0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            rsp_o   <= 1'b0;
            req_o   <= 1'b0;
            wr_o    <= 1'b0;
            cmd_o   <= '0;
            addr_o  <= '0;
            wdata_o <= '0;
            abort_o <= 1'b0;
        end else begin
            abort_o <= abort_evt;
            if (abort_evt) begin
                req_o   <= 1'b0;
                rsp_o   <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                    end
                    ST_RX: begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == '0) rx_wr <= cmd_i;
                        else               rx_sr <= rx_sr_nxt;
                        if (rx_done) begin
                            req_o   <= 1'b1;
                            wr_o    <= rx_wr;
                            bit_cnt <= '0;
                            // Write frames fill the whole register; reads only the low HDR_W bits
                            if (rx_wr) begin
                                cmd_o   <= rx_sr_nxt[PAY_W-1 -: g_cmd_w];
                                addr_o  <= rx_sr_nxt[g_data_w +: g_addr_w];
                                wdata_o <= rx_sr_nxt[g_data_w-1:0];
                            end else begin
                                cmd_o   <= rx_sr_nxt[HDR_W-1 -: g_cmd_w];
                                addr_o  <= rx_sr_nxt[g_addr_w-1:0];
                                wdata_o <= '0;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (ack_evt) begin
                            req_o   <= 1'b0;
                            rsp_o   <= 1'b1;
                            bit_cnt <= CNT_W'(1);
                            tx_sr   <= {wr_o, cmd_o, addr_o, rsp_data};
                        end
                    end
                    ST_TX: begin
                        if (tx_done) begin
                            rsp_o   <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            rsp_o   <= tx_sr[TXS_W-1];
                            tx_sr   <= {tx_sr[TXS_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        rsp_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_saci_slave.sv
// Directed and randomized frames for saci_slave, checked against frame/response
// vectors built from the protocol rules.
module tb_saci_slave;
    localparam int CW = 7;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk_i     = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          sel_n_i   = 1'b1;
    logic          cmd_i     = 1'b0;
    logic          ack_i     = 1'b0;
    logic [DW-1:0] rdata_i   = '0;
    logic          rsp_o, req_o, wr_o, abort_o, busy_o;
    logic [CW-1:0] cmd_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;

    int   n_cmp = 0;
    int   n_err = 0;
    int   abort_cnt = 0;
    int   req_cnt = 0;
    logic req_prev = 1'b0;

    always #5 clk_i = ~clk_i;

    saci_slave #(.g_cmd_w(CW), .g_addr_w(AW), .g_data_w(DW)) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .sel_n_i  (sel_n_i),
        .cmd_i    (cmd_i),
        .rsp_o    (rsp_o),
        .req_o    (req_o),
        .wr_o     (wr_o),
        .cmd_o    (cmd_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .rdata_i  (rdata_i),
        .ack_i    (ack_i),
        .abort_o  (abort_o),
        .busy_o   (busy_o)
    );

    // Event counters sampled shortly after each rising edge
    always @(posedge clk_i) begin
        #2;
        if (abort_o) abort_cnt++;
        if (req_o && !req_prev) req_cnt++;
        req_prev = req_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input logic wr);
        return wr ? 2 + CW + AW + DW : 2 + CW + AW;
    endfunction

    function automatic int resp_len(input logic wr);
        return wr ? 2 + CW + AW : 2 + CW + AW + DW;
    endfunction

    function automatic logic [63:0] frame_bits(input logic wr, input logic [CW-1:0] c,
                                               input logic [AW-1:0] a, input logic [DW-1:0] d);
        return wr ? {11'd0, 1'b1, 1'b1, c, a, d} : {43'd0, 1'b1, 1'b0, c, a};
    endfunction

    function automatic logic [63:0] resp_bits(input logic wr, input logic [CW-1:0] c,
                                              input logic [AW-1:0] a, input logic [DW-1:0] rd);
        return wr ? {43'd0, 1'b1, 1'b1, c, a} : {11'd0, 1'b1, 1'b0, c, a, rd};
    endfunction

    // Drive the first n bits of a total-bit frame, MSB first
    task automatic send_bits(input logic [63:0] vec, input int n, input int total);
        for (int i = 0; i < n; i++) begin
            sel_n_i = 1'b0;
            cmd_i   = vec[total-1-i];
            @(negedge clk_i);
        end
        cmd_i = 1'b0;
    endtask

    task automatic do_xact(input logic wr, input logic [CW-1:0] c, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] rd, input int lat,
                           input bit release_sel, input string tag);
        int          r0;
        int          a0;
        int          rl;
        logic [63:0] obs;
        r0 = req_cnt;
        a0 = abort_cnt;
        send_bits(frame_bits(wr, c, a, d), frame_len(wr), frame_len(wr));
        chk({tag, ".req"}, 64'(req_o), 64'(1));
        chk({tag, ".wr"}, 64'(wr_o), 64'(wr));
        chk({tag, ".cmd"}, 64'(cmd_o), 64'(c));
        chk({tag, ".addr"}, 64'(addr_o), 64'(a));
        if (wr) chk({tag, ".wdata"}, 64'(wdata_o), 64'(d));
        for (int k = 0; k < lat; k++) begin
            @(negedge clk_i);
            chk({tag, ".hold"}, {req_o, wr_o, cmd_o, addr_o}, {1'b1, wr, c, a});
        end
        ack_i   = 1'b1;
        rdata_i = rd;
        @(negedge clk_i);
        ack_i   = 1'b0;
        rdata_i = $urandom;
        chk({tag, ".req_drop"}, 64'(req_o), 64'(0));
        rl  = resp_len(wr);
        obs = '0;
        for (int i = 0; i < rl; i++) begin
            obs   = {obs[62:0], rsp_o};
            ack_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
        end
        ack_i = 1'b0;
        chk({tag, ".resp"}, obs, resp_bits(wr, c, a, rd));
        chk({tag, ".resp_end"}, {rsp_o, req_o, busy_o}, {1'b0, 1'b0, 1'b1});
        if (release_sel) begin
            sel_n_i = 1'b1;
            @(negedge clk_i);
            chk({tag, ".idle"}, 64'(busy_o), 64'(0));
        end
        chk({tag, ".nreq"}, 64'(req_cnt - r0), 64'(1));
        chk({tag, ".nabort"}, 64'(abort_cnt - a0), 64'(0));
    endtask

    initial begin
        int          r0;
        int          a0;
        logic        acc;
        logic        wr;
        logic [CW-1:0] c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        repeat (3) @(negedge clk_i);
        chk("reset_out", {rsp_o, req_o, wr_o, abort_o, busy_o}, 64'(0));
        chk("reset_fields", {cmd_o, addr_o, wdata_o}, 64'(0));
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // line idle while selected must not start a frame
        sel_n_i = 1'b0;
        cmd_i   = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("idle_low", 64'(busy_o), 64'(0));
        sel_n_i = 1'b1;
        @(negedge clk_i);

        do_xact(1'b1, 7'h15, 12'hABC, 32'hDEADBEEF, 32'h0, 3, 1'b1, "wr_dir");
        do_xact(1'b0, 7'h01, 12'h010, 32'h0, 32'h12345678, 0, 1'b1, "rd_dir");

        for (int n = 0; n < 8; n++) begin
            wr = 1'($urandom_range(0, 1));
            c  = 7'($urandom_range(0, 127));
            a  = 12'($urandom_range(0, 4095));
            d  = $urandom;
            do_xact(wr, c, a, d, $urandom, int'($urandom_range(0, 4)), 1'b1, "rand");
        end

        // abort after 10 bits of a write frame
        r0 = req_cnt;
        a0 = abort_cnt;
        send_bits(frame_bits(1'b1, 7'h33, 12'h123, 32'hCAFEF00D), 10, frame_len(1'b1));
        sel_n_i = 1'b1;
        @(negedge clk_i);
        chk("rx_abort", {abort_o, busy_o, req_o}, {1'b1, 1'b0, 1'b0});
        @(negedge clk_i);
        chk("rx_abort_pulse", 64'(abort_o), 64'(0));
        chk("rx_abort_cnt", 64'(abort_cnt - a0), 64'(1));
        chk("rx_abort_noreq", 64'(req_cnt - r0), 64'(0));
        do_xact(1'b0, 7'h42, 12'h7FF, 32'h0, $urandom, 1, 1'b1, "after_abort");

        // abort in ST_REQ with ack on the same edge
        a0 = abort_cnt;
        send_bits(frame_bits(1'b0, 7'h0C, 12'h456, 32'h0), frame_len(1'b0), frame_len(1'b0));
        chk("req_abort_pre", 64'(req_o), 64'(1));
        sel_n_i = 1'b1;
        ack_i   = 1'b1;
        rdata_i = $urandom;
        @(negedge clk_i);
        ack_i = 1'b0;
        chk("req_abort", {abort_o, req_o, rsp_o, busy_o}, {1'b1, 1'b0, 1'b0, 1'b0});
        acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            acc = acc | rsp_o | abort_o | busy_o;
        end
        chk("req_abort_quiet", 64'(acc), 64'(0));
        chk("req_abort_cnt", 64'(abort_cnt - a0), 64'(1));

        // back-to-back frames with sel_n_i held low: second one ignored
        do_xact(1'b1, 7'h05, 12'h0F0, 32'h01020304, 32'h0, 2, 1'b0, "b2b_first");
        r0 = req_cnt;
        send_bits(frame_bits(1'b0, 7'h06, 12'h0F1, 32'h0), frame_len(1'b0), frame_len(1'b0));
        repeat (2) @(negedge clk_i);
        chk("b2b_ignored", {req_o, busy_o}, {1'b0, 1'b1});
        chk("b2b_nreq", 64'(req_cnt - r0), 64'(0));
        sel_n_i = 1'b1;
        @(negedge clk_i);
        do_xact(1'b0, 7'h06, 12'h0F1, 32'h0, 32'hA5A55A5A, 0, 1'b1, "b2b_second");

        // asynchronous reset during ST_TX
        a0 = abort_cnt;
        send_bits(frame_bits(1'b1, 7'h7F, 12'hFFF, 32'h55AA55AA), frame_len(1'b1), frame_len(1'b1));
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        @(negedge clk_i);
        chk("rst_tx_pre", {rsp_o, busy_o}, {1'b1, 1'b1});
        #2 reset_n_i = 1'b0;
        #1;
        chk("rst_tx", {rsp_o, req_o, busy_o, abort_o}, 64'(0));
        @(negedge clk_i);
        sel_n_i   = 1'b1;
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_tx_noabort", 64'(abort_cnt - a0), 64'(0));
        chk("rst_tx_idle", {rsp_o, busy_o}, 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
